// File: rtl/sd_rw_seq_ctrl.sv
// UART-to-SD sector sequencer: packs rx bytes into a write FIFO, writes/reads a ring of SD sectors
// and streams the readback to UART TX. Define SD_RW_CHKSUM_EN to enable the readback checksum.
module sd_rw_seq_ctrl #(
    parameter int          SECTOR_BYTES = 512,
    parameter int          SECTOR_NUM   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'd1000,
    parameter int          TX_GAP       = 60000,
    parameter int          WBUF_AW      = 10
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        init_end,
    input  logic                        rx_flag,
    input  logic [7:0]                  rx_data,
    input  logic                        wr_req,
    input  logic                        wr_busy,
    output logic                        wr_en,
    output logic [31:0]                 wr_addr,
    output logic [15:0]                 wr_data,
    input  logic                        rd_data_en,
    input  logic [15:0]                 rd_data,
    input  logic                        rd_busy,
    output logic                        rd_en,
    output logic [31:0]                 rd_addr,
    output logic                        tx_flag,
    output logic [7:0]                  tx_data,
    output logic [$clog2(SECTOR_NUM):0] sec_idx,
    output logic                        ovf,
    output logic                        chk_err
);
    localparam int SECTOR_WORDS = SECTOR_BYTES / 2;
    localparam int WBUF_DEPTH   = 2 ** WBUF_AW;
    localparam int RB_AW        = $clog2(SECTOR_WORDS);
    localparam int BYTE_W       = $clog2(SECTOR_BYTES + 1);
    localparam int GAP_W        = $clog2(TX_GAP);
    localparam int IDX_W        = $clog2(SECTOR_NUM) + 1;
    localparam logic [WBUF_AW:0]  SW_CNT    = (WBUF_AW + 1)'(SECTOR_WORDS);
    localparam logic [RB_AW:0]    RB_FULL   = (RB_AW + 1)'(SECTOR_WORDS);
    localparam logic [BYTE_W-1:0] LAST_CNT  = BYTE_W'(SECTOR_BYTES);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TX_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SECTOR_NUM - 1);

    typedef enum logic [2:0] {IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, TX} state_t;
    state_t state_reg, state_next;

    logic              byte_sel_reg;
    logic [7:0]        hi_byte_reg;
    logic [15:0]       wbuf_mem [WBUF_DEPTH];
    logic [WBUF_AW:0]  wbuf_wptr_reg, wbuf_rptr_reg, wbuf_count;
    logic              wbuf_full, wbuf_empty, word_done, wbuf_push, wbuf_pop;
    logic              wr_busy_d_reg, rd_busy_d_reg, wr_busy_fall, rd_busy_fall;
    logic [15:0]       rbuf_mem [SECTOR_WORDS];
    logic [RB_AW:0]    rbuf_cnt_reg;
    logic              rd_store;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [BYTE_W-1:0] byte_cnt_reg;
    logic [15:0]       tx_word;
    logic              tx_done;
    logic              wr_en_reg, rd_en_reg, tx_flag_reg, ovf_reg;
    logic [7:0]        tx_data_reg;
    logic [IDX_W-1:0]  sec_idx_reg;

    // The word completes on the second byte of each pair; the packer toggles even if it is dropped.
    assign word_done  = rx_flag & byte_sel_reg;
    assign wbuf_count = wbuf_wptr_reg - wbuf_rptr_reg;
    assign wbuf_full  = wbuf_count[WBUF_AW];
    assign wbuf_empty = (wbuf_count == '0);
    assign wbuf_push  = word_done & ~wbuf_full;
    assign wbuf_pop   = wr_req & ~wbuf_empty;
    assign wr_data    = wbuf_mem[wbuf_rptr_reg[WBUF_AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_sel_reg  <= 1'b0;
            hi_byte_reg   <= '0;
            wbuf_wptr_reg <= '0;
            wbuf_rptr_reg <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            if (rx_flag) begin
                byte_sel_reg <= ~byte_sel_reg;
                if (!byte_sel_reg)
                    hi_byte_reg <= rx_data;
            end
            if (wbuf_push)
                wbuf_wptr_reg <= wbuf_wptr_reg + 1'b1;
            if (wbuf_pop)
                wbuf_rptr_reg <= wbuf_rptr_reg + 1'b1;
            if (word_done && wbuf_full)
                ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < WBUF_DEPTH; i++)
                wbuf_mem[i] <= '0;
        end else if (wbuf_push) begin
            wbuf_mem[wbuf_wptr_reg[WBUF_AW-1:0]] <= {hi_byte_reg, rx_data};
        end
    end

    assign wr_busy_fall = ~wr_busy & wr_busy_d_reg;
    assign rd_busy_fall = ~rd_busy & rd_busy_d_reg;
    assign tx_done      = (state_reg == TX) && (byte_cnt_reg == LAST_CNT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (init_end && wbuf_count >= SW_CNT) state_next = WR_START;
            WR_START: state_next = WR_WAIT;
            WR_WAIT:  if (wr_busy_fall) state_next = RD_START;
            RD_START: state_next = RD_WAIT;
            RD_WAIT:  if (rd_busy_fall) state_next = TX;
            TX:       if (tx_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Start strobes are registered from the next state so they coincide with the start states.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            wr_en_reg     <= 1'b0;
            rd_en_reg     <= 1'b0;
            wr_busy_d_reg <= 1'b0;
            rd_busy_d_reg <= 1'b0;
            sec_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            wr_en_reg     <= (state_next == WR_START);
            rd_en_reg     <= (state_next == RD_START);
            wr_busy_d_reg <= wr_busy;
            rd_busy_d_reg <= rd_busy;
            if (tx_done)
                sec_idx_reg <= (sec_idx_reg == IDX_LAST) ? '0 : sec_idx_reg + 1'b1;
        end
    end

    assign rd_store = (state_reg == RD_WAIT) && rd_data_en && (rbuf_cnt_reg < RB_FULL);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rbuf_cnt_reg <= '0;
            for (int i = 0; i < SECTOR_WORDS; i++)
                rbuf_mem[i] <= '0;
        end else if (state_reg == RD_START) begin
            rbuf_cnt_reg <= '0;
            for (int i = 0; i < SECTOR_WORDS; i++)
                rbuf_mem[i] <= '0;
        end else if (rd_store) begin
            rbuf_mem[rbuf_cnt_reg[RB_AW-1:0]] <= rd_data;
            rbuf_cnt_reg <= rbuf_cnt_reg + 1'b1;
        end
    end

    assign tx_word = rbuf_mem[byte_cnt_reg[RB_AW:1]];

    // Gap counter restarts on every TX entry, so the first byte goes out TX_GAP cycles later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            tx_flag_reg  <= 1'b0;
            tx_data_reg  <= '0;
        end else if (state_reg != TX) begin
            gap_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            tx_flag_reg  <= 1'b0;
        end else begin
            tx_flag_reg <= 1'b0;
            if (byte_cnt_reg != LAST_CNT) begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_reg  <= '0;
                    tx_flag_reg  <= 1'b1;
                    tx_data_reg  <= byte_cnt_reg[0] ? tx_word[7:0] : tx_word[15:8];
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end else begin
                    gap_cnt_reg <= gap_cnt_reg + 1'b1;
                end
            end
        end
    end

`ifdef SD_RW_CHKSUM_EN
    logic [15:0] wsum_reg, rsum_reg;
    logic        chk_err_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wsum_reg    <= '0;
            rsum_reg    <= '0;
            chk_err_reg <= 1'b0;
        end else if (state_reg == WR_START) begin
            wsum_reg <= '0;
            rsum_reg <= '0;
        end else begin
            if (state_reg == WR_WAIT && wbuf_pop)
                wsum_reg <= wsum_reg + wr_data;
            if (rd_store)
                rsum_reg <= rsum_reg + rd_data;
            if (state_reg == RD_WAIT && rd_busy_fall && wsum_reg != rsum_reg)
                chk_err_reg <= 1'b1;
        end
    end

    assign chk_err = chk_err_reg;
`else
    assign chk_err = 1'b0;
`endif

    assign wr_en   = wr_en_reg;
    assign rd_en   = rd_en_reg;
    assign tx_flag = tx_flag_reg;
    assign tx_data = tx_data_reg;
    assign sec_idx = sec_idx_reg;
    assign ovf     = ovf_reg;
    assign wr_addr = BASE_ADDR + 32'(sec_idx_reg);
    assign rd_addr = BASE_ADDR + 32'(sec_idx_reg);

endmodule
